mpu_sequencer: RTL and testbench
================================

# mpu_sequencer

Command-driven controller that sequences the combinational-per-clock MPU operations datapath (add, sub, scalar multiply, opposite, transpose on 5x5 signed 8-bit matrices). It accepts one command, streams operand elements in byte-serially, holds operands and opcode stable while the datapath computes, captures the result and streams the active `size`×`size` region out. It sits between the host byte interface and the datapath; one command is in flight at a time.

## Interface
- `DIM_MAX`, 5, maximum matrix dimension; datapath vectors are `DIM_MAX*DIM_MAX*ELEM_WIDTH` bits
- `ELEM_WIDTH`, 8, signed element width
- `clock` in 1 — single clock, all state on rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `cmd_valid` in 1 / `cmd_ready` out 1 — command handshake
- `cmd_opcode` in 3 — 0 add, 1 sub, 2 scalar mul, 3 opposite, 4 transpose; 5–7 rejected
- `cmd_size` in 8 — active dimension, legal 1..`DIM_MAX`
- `cmd_factor` in 8 — signed scalar for opcode 2
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 8 — operand element stream, row-major
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out 8 — result element stream, row-major
- `done` out 1 — one-cycle pulse after last result element accepted
- `cmd_error` out 1 — one-cycle pulse on rejected command
- `mpu_operation` out 3, `mpu_size` out 8, `mpu_factor` out 8 — to datapath
- `mpu_matrix_a`, `mpu_matrix_b` out 200 — operand vectors to datapath
- `mpu_result` in 200 — datapath registered result

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, STORE.
- IDLE: `cmd_ready`=1. On `cmd_valid&cmd_ready`: latch opcode/size/factor, clear A and B registers to zero, reset row/col counters. Opcode ≥5 or size 0 or size >`DIM_MAX` → pulse `cmd_error` next cycle, stay IDLE, no load.
- LOAD_A: `in_ready`=1; each accepted byte written to element (row,col) = flat lane 5·row+col, lane k = bits [8k +: 8] of the ascending 0-based vector. Col wraps at size−1 and increments row. After size² elements: LOAD_B if opcode 0/1, else EXEC.
- LOAD_B: identical, into B; then EXEC.
- EXEC: drive `mpu_operation`=latched opcode (operands already stable); one cycle. Outside EXEC/CAPTURE `mpu_operation` held at latched value; datapath output ignored.
- CAPTURE: latch `mpu_result` into result register; one cycle; counters reset; → STORE.
- STORE: `out_valid`=1, `out_data`=result element (row,col); advance on `out_valid&out_ready`. After size² transfers: pulse `done`, → IDLE.
- Lanes outside active region are zero in A/B; padding never streamed out.
- Arithmetic is entirely in the datapath (8-bit wrap); sequencer never modifies data.

## Timing
- Reset values: state IDLE, `cmd_ready`=1 after reset release, `in_ready`/`out_valid`/`done`/`cmd_error`=0, `out_data`=0, all `mpu_*` outputs and A/B/result registers 0.
- Command accepted at edge T: LOAD_A from T+1; `in_ready` combinational from state.
- Minimum latency (opcode 3, size 1, `in_valid` held): byte accepted at T+1, EXEC T+2, CAPTURE T+3, `out_valid` at T+4.
- `out_data` stable while `out_valid`&!`out_ready`; `in_valid` low stalls counters without loss.
- `cmd_valid` ignored outside IDLE; `cmd_ready`=0 from accept until return to IDLE.
- `done` asserted in the cycle after the final out handshake, coincident with `cmd_ready`=1; a new command may be accepted that same cycle.
- `reset_n` low at any point: immediate return to reset values; partial loads discarded; no `done`.

## Structure
- Package `mpu_pkg`: opcode constants, `DIM_MAX`, `ELEM_WIDTH`, state enum, legal-opcode/needs-B helper functions.
- Sub-module `mpu_element_counter`: row/col counter with size-dependent wrap, `clear`, `advance`, `last` flag, flat-index output; instantiated once, shared by load and store phases.

## Test plan
- Add, size 2: A=1,2,3,4; B=10,20,30,40 → out 11,22,33,44, `done` pulse, 8 input bytes taken.
- Scalar mul, size 3, factor −2: A=1..9 → out −2,−4,…,−18; B phase skipped (only 9 input handshakes).
- Transpose, size 5, random A with `out_ready` toggling every other cycle → out is Aᵀ row-major, `out_data` held during stalls.
- Opcode 6 and size 0 and size 6 → `cmd_error` pulse, no `in_ready`, state IDLE.
- Opposite, size 1, A=−128 → out −128 (wrap); latency exactly T+4 to `out_valid`.
- `reset_n` asserted mid-LOAD_B → all outputs at reset values; next add command runs cleanly with stale lanes zero.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared constants, opcode encodings, sequencer state type and command
// decode helpers for the MPU sequencer.
package mpu_pkg;

    localparam int DIM_MAX    = 5;
    localparam int ELEM_WIDTH = 8;
    localparam int VEC_WIDTH  = DIM_MAX * DIM_MAX * ELEM_WIDTH;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_SMUL  = 3'd2;
    localparam logic [2:0] OP_OPP   = 3'd3;
    localparam logic [2:0] OP_TRANS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_EXEC    = 3'd3,
        S_CAPTURE = 3'd4,
        S_STORE   = 3'd5
    } state_t;

    function automatic logic cmd_is_legal(input logic [2:0] op, input logic [7:0] size);
        return (op <= OP_TRANS) && (size != 8'd0) && (size <= 8'(DIM_MAX));
    endfunction

    function automatic logic op_needs_b(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mpu_element_counter.sv
// Row/column walker over the active size x size region; the flat index is
// the lane number in the DIM_MAX-strided operand/result vectors.
module mpu_element_counter
    import mpu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_advance,
    input  logic [2:0] i_size,
    output logic       o_last,
    output logic [4:0] o_index
);

    localparam logic [4:0] STRIDE = 5'(DIM_MAX);

    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [2:0] w_max;
    logic       w_col_wrap;

    assign w_max      = i_size - 3'd1;
    assign w_col_wrap = (r_col == w_max);
    assign o_last     = w_col_wrap && (r_row == w_max);
    assign o_index    = ({2'b00, r_row} * STRIDE) + {2'b00, r_col};

    // Wrapping on the last element leaves the counter at (0,0) for the next phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= o_last ? 3'd0 : r_row + 3'd1;
            end else begin
                r_col <= r_col + 3'd1;
            end
        end
    end

endmodule

// File: rtl/mpu_sequencer.sv
// Command sequencer for the MPU datapath: loads operands byte-serially,
// runs one datapath evaluation, captures the result and streams it out.
module mpu_sequencer
    import mpu_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_opcode,
    input  logic [7:0]            cmd_size,
    input  logic [7:0]            cmd_factor,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ELEM_WIDTH-1:0] out_data,
    output logic                  done,
    output logic                  cmd_error,
    output logic [2:0]            mpu_operation,
    output logic [7:0]            mpu_size,
    output logic [7:0]            mpu_factor,
    output logic [VEC_WIDTH-1:0]  mpu_matrix_a,
    output logic [VEC_WIDTH-1:0]  mpu_matrix_b,
    input  logic [VEC_WIDTH-1:0]  mpu_result,
    output logic [2:0]            dbg_state
);

    state_t               r_state;
    logic [2:0]           r_op;
    logic [7:0]           r_size;
    logic [7:0]           r_factor;
    logic [VEC_WIDTH-1:0] r_mat_a;
    logic [VEC_WIDTH-1:0] r_mat_b;
    logic [VEC_WIDTH-1:0] r_result;
    logic                 r_done;
    logic                 r_cmd_error;

    logic       w_cmd_fire;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_last;
    logic [4:0] w_index;

    // All three streams transfer on a cycle where valid && ready; valid never
    // depends on ready, and the producer holds data stable until the transfer.
    assign cmd_ready  = (r_state == S_IDLE);
    assign in_ready   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign out_valid  = (r_state == S_STORE);
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    mpu_element_counter u_counter (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_clear   (w_cmd_fire || (r_state == S_CAPTURE)),
        .i_advance (w_in_fire || w_out_fire),
        .i_size    (r_size[2:0]),
        .o_last    (w_last),
        .o_index   (w_index)
    );

    assign out_data      = r_result[w_index*ELEM_WIDTH +: ELEM_WIDTH];
    assign done          = r_done;
    assign cmd_error     = r_cmd_error;
    assign mpu_operation = r_op;
    assign mpu_size      = r_size;
    assign mpu_factor    = r_factor;
    assign mpu_matrix_a  = r_mat_a;
    assign mpu_matrix_b  = r_mat_b;
    assign dbg_state     = r_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_size      <= '0;
            r_factor    <= '0;
            r_mat_a     <= '0;
            r_mat_b     <= '0;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_cmd_error <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        // Rejected commands leave the previous operands untouched.
                        if (cmd_is_legal(cmd_opcode, cmd_size)) begin
                            r_op     <= cmd_opcode;
                            r_size   <= cmd_size;
                            r_factor <= cmd_factor;
                            r_mat_a  <= '0;
                            r_mat_b  <= '0;
                            r_state  <= S_LOAD_A;
                        end else begin
                            r_cmd_error <= 1'b1;
                        end
                    end
                end
                S_LOAD_A: begin
                    if (w_in_fire) begin
                        r_mat_a[w_index*ELEM_WIDTH +: ELEM_WIDTH] <= in_data;
                        if (w_last) r_state <= op_needs_b(r_op) ? S_LOAD_B : S_EXEC;
                    end
                end
                S_LOAD_B: begin
                    if (w_in_fire) begin
                        r_mat_b[w_index*ELEM_WIDTH +: ELEM_WIDTH] <= in_data;
                        if (w_last) r_state <= S_EXEC;
                    end
                end
                S_EXEC: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_result <= mpu_result;
                    r_state  <= S_STORE;
                end
                S_STORE: begin
                    if (w_out_fire && w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_sequencer.sv
// Self-checking bench for mpu_sequencer: a behavioural datapath stand-in,
// command/stream drivers, and an output monitor popping an expected queue.
module tb_mpu_sequencer;
    import mpu_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_opcode = '0;
    logic [7:0]   cmd_size = '0;
    logic [7:0]   cmd_factor = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_data;
    logic         done;
    logic         cmd_error;
    logic [2:0]   mpu_operation;
    logic [7:0]   mpu_size;
    logic [7:0]   mpu_factor;
    logic [199:0] mpu_matrix_a;
    logic [199:0] mpu_matrix_b;
    logic [199:0] mpu_result = '0;
    logic [2:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ov_cyc = 0;
    int done_cnt = 0;
    int in_hs_cnt = 0;
    int ready_mode = 0;
    bit prev_stall = 0;
    bit prev_valid = 0;
    bit done_pending = 0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_q[$];
    logic [7:0] stim_a[25];
    logic [7:0] stim_b[25];

    mpu_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_size(cmd_size), .cmd_factor(cmd_factor),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .cmd_error(cmd_error),
        .mpu_operation(mpu_operation), .mpu_size(mpu_size), .mpu_factor(mpu_factor),
        .mpu_matrix_a(mpu_matrix_a), .mpu_matrix_b(mpu_matrix_b),
        .mpu_result(mpu_result), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset support ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- datapath stand-in (registered, all 25 lanes) ----------------
    function automatic logic [199:0] dp_eval(input logic [199:0] a, input logic [199:0] b,
                                             input logic [2:0] op, input logic [7:0] f);
        logic [199:0] r;
        r = '0;
        for (int k = 0; k < 25; k++) begin
            logic signed [7:0] ea, eb, fs;
            ea = a[8*k +: 8];
            eb = b[8*k +: 8];
            fs = f;
            case (op)
                3'd0: r[8*k +: 8] = ea + eb;
                3'd1: r[8*k +: 8] = ea - eb;
                3'd2: r[8*k +: 8] = ea * fs;
                3'd3: r[8*k +: 8] = -ea;
                3'd4: r[8*k +: 8] = a[8*((k % 5) * 5 + (k / 5)) +: 8];
                default: r[8*k +: 8] = 8'd0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clock) mpu_result <= dp_eval(mpu_matrix_a, mpu_matrix_b, mpu_operation, mpu_factor);

    // ---------------- check helpers ----------------
    function automatic void check(input bit ok, input string name, input int act, input int exp_v);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    function automatic int lane_diff(input logic [199:0] a, input logic [199:0] b);
        int n;
        n = 0;
        for (int k = 0; k < 25; k++) if (a[8*k +: 8] !== b[8*k +: 8]) n++;
        return n;
    endfunction

    // ---------------- out_ready pattern driver ----------------
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall   = 0;
            prev_valid   = 0;
            done_pending = 0;
        end else begin
            if (prev_stall) begin
                check(out_valid === 1'b1, "out_valid_hold", out_valid, 1);
                check(out_data === prev_data, "out_data_hold", out_data, prev_data);
            end
            if (done_pending) begin
                check(done === 1'b1, "done_pulse", done, 1);
                check(cmd_ready === 1'b1, "done_with_cmd_ready", cmd_ready, 1);
                done_pending = 0;
            end else begin
                check(done === 1'b0, "done_spurious", done, 0);
            end
            if (done) done_cnt++;
            if (in_valid && in_ready) in_hs_cnt++;
            if (out_valid && !prev_valid) ov_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "out_unexpected", out_data, -1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check(out_data === e, "out_data", $signed(out_data), $signed(e));
                    if (exp_q.size() == 0) done_pending = 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_valid = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] size, input logic [7:0] f);
        bit rdy;
        int guard;
        rdy = 0;
        guard = 0;
        @(posedge clock);
        #1;
        cmd_opcode = op;
        cmd_size   = size;
        cmd_factor = f;
        cmd_valid  = 1'b1;
        do begin
            @(negedge clock);
            rdy = cmd_ready;
            @(posedge clock);
            guard++;
        end while (!rdy && guard < 200);
        #1;
        cmd_valid  = 1'b0;
        cmd_opcode = 3'($urandom);
        acc_cyc    = cyc;
        check(rdy, "cmd_accept", rdy, 1);
    endtask

    task automatic send_stream(input bit use_b, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            bit hs;
            int guard;
            int gap;
            hs = 0;
            guard = 0;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            in_data  = use_b ? stim_b[i] : stim_a[i];
            in_valid = 1'b1;
            while (!hs && guard < 200) begin
                @(negedge clock);
                hs = in_ready;
                check(cmd_ready === 1'b0, "cmd_ready_busy", cmd_ready, 0);
                @(posedge clock);
                #1;
                guard++;
            end
            check(hs, "in_accept", hs, 1);
        end
        in_valid = 1'b0;
    endtask

    // Reference: results indexed by stream position, independent of lane layout.
    task automatic run_cmd(input logic [2:0] op, input int size, input logic [7:0] f,
                           input int max_gap, input int rmode);
        logic [199:0] va, vb;
        bit need_b;
        int base_in, base_done, guard, n_in;
        va = '0;
        vb = '0;
        need_b = (op == 3'd0) || (op == 3'd1);
        ready_mode = rmode;
        for (int r = 0; r < size; r++) begin
            for (int c = 0; c < size; c++) begin
                logic signed [7:0] ea, eb, fs, e;
                ea = stim_a[r*size + c];
                eb = stim_b[r*size + c];
                fs = f;
                case (op)
                    3'd0: e = ea + eb;
                    3'd1: e = ea - eb;
                    3'd2: e = ea * fs;
                    3'd3: e = -ea;
                    default: e = stim_a[c*size + r];
                endcase
                exp_q.push_back(e);
                va[8*(5*r + c) +: 8] = stim_a[r*size + c];
                if (need_b) vb[8*(5*r + c) +: 8] = stim_b[r*size + c];
            end
        end
        n_in = need_b ? 2 * size * size : size * size;
        base_in = in_hs_cnt;
        base_done = done_cnt;
        send_cmd(op, 8'(size), f);
        send_stream(1'b0, size * size, max_gap);
        if (need_b) send_stream(1'b1, size * size, max_gap);
        guard = 0;
        while (done_cnt == base_done && guard < 2000) begin
            @(posedge clock);
            guard++;
        end
        @(negedge clock);
        check(done_cnt == base_done + 1, "done_count", done_cnt - base_done, 1);
        check(in_hs_cnt - base_in == n_in, "in_handshakes", in_hs_cnt - base_in, n_in);
        check(exp_q.size() == 0, "out_count_left", exp_q.size(), 0);
        check(lane_diff(mpu_matrix_a, va) == 0, "lanes_a", lane_diff(mpu_matrix_a, va), 0);
        check(lane_diff(mpu_matrix_b, vb) == 0, "lanes_b", lane_diff(mpu_matrix_b, vb), 0);
        check(mpu_operation == op, "mpu_operation", mpu_operation, op);
        check(mpu_size == 8'(size), "mpu_size", mpu_size, size);
        check(mpu_factor == f, "mpu_factor", mpu_factor, f);
        check(dbg_state == S_IDLE, "state_idle_after", dbg_state, S_IDLE);
        exp_q.delete();
    endtask

    task automatic check_reset_values();
        check(in_ready === 1'b0, "rst_in_ready", in_ready, 0);
        check(out_valid === 1'b0, "rst_out_valid", out_valid, 0);
        check(done === 1'b0, "rst_done", done, 0);
        check(cmd_error === 1'b0, "rst_cmd_error", cmd_error, 0);
        check(out_data === 8'd0, "rst_out_data", out_data, 0);
        check(mpu_operation === 3'd0, "rst_mpu_operation", mpu_operation, 0);
        check(mpu_size === 8'd0, "rst_mpu_size", mpu_size, 0);
        check(mpu_factor === 8'd0, "rst_mpu_factor", mpu_factor, 0);
        check(mpu_matrix_a === '0, "rst_mpu_matrix_a", lane_diff(mpu_matrix_a, '0), 0);
        check(mpu_matrix_b === '0, "rst_mpu_matrix_b", lane_diff(mpu_matrix_b, '0), 0);
        check(dbg_state === S_IDLE, "rst_state", dbg_state, S_IDLE);
    endtask

    task automatic reject_cmd(input logic [2:0] op, input logic [7:0] size);
        send_cmd(op, size, 8'd1);
        @(negedge clock);
        check(cmd_error === 1'b1, "cmd_error_pulse", cmd_error, 1);
        check(in_ready === 1'b0, "err_in_ready", in_ready, 0);
        check(dbg_state === S_IDLE, "err_state", dbg_state, S_IDLE);
        check(cmd_ready === 1'b1, "err_cmd_ready", cmd_ready, 1);
        @(negedge clock);
        check(cmd_error === 1'b0, "cmd_error_single", cmd_error, 0);
        check(in_ready === 1'b0, "err_in_ready_2", in_ready, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check(cmd_ready === 1'b1, "cmd_ready_after_reset", cmd_ready, 1);

        // Add, size 2
        stim_a[0] = 8'd1;  stim_a[1] = 8'd2;  stim_a[2] = 8'd3;  stim_a[3] = 8'd4;
        stim_b[0] = 8'd10; stim_b[1] = 8'd20; stim_b[2] = 8'd30; stim_b[3] = 8'd40;
        run_cmd(3'd0, 2, 8'd0, 2, 0);

        // Scalar multiply, size 3, factor -2
        for (int i = 0; i < 9; i++) stim_a[i] = 8'(i + 1);
        run_cmd(3'd2, 3, 8'hFE, 1, 0);

        // Transpose, size 5, out_ready toggling
        for (int i = 0; i < 25; i++) stim_a[i] = 8'($urandom);
        run_cmd(3'd4, 5, 8'd0, 1, 1);

        // Rejected commands
        reject_cmd(3'd6, 8'd1);
        reject_cmd(3'd0, 8'd0);
        reject_cmd(3'd1, 8'd6);

        // Opposite of -128, size 1, back-to-back input: minimum latency
        stim_a[0] = 8'h80;
        run_cmd(3'd3, 1, 8'd0, 0, 0);
        check(ov_cyc - acc_cyc == 3, "min_latency_edges", ov_cyc - acc_cyc, 3);

        // Random commands
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 25; i++) begin
                stim_a[i] = 8'($urandom);
                stim_b[i] = 8'($urandom);
            end
            run_cmd(3'($urandom_range(0, 4)), int'($urandom_range(1, 5)), 8'($urandom),
                    2, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of LOAD_B, then a clean add
        for (int i = 0; i < 25; i++) begin
            stim_a[i] = 8'($urandom_range(1, 255));
            stim_b[i] = 8'($urandom_range(1, 255));
        end
        send_cmd(3'd0, 8'd3, 8'd0);
        send_stream(1'b0, 9, 1);
        send_stream(1'b1, 2, 1);
        check(dbg_state === S_LOAD_B, "in_load_b", dbg_state, S_LOAD_B);
        reset_n = 1'b0;
        @(negedge clock);
        check_reset_values();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check(cmd_ready === 1'b1, "cmd_ready_after_reset2", cmd_ready, 1);
        check_reset_values();
        for (int i = 0; i < 4; i++) begin
            stim_a[i] = 8'($urandom);
            stim_b[i] = 8'($urandom);
        end
        run_cmd(3'd0, 2, 8'd0, 1, 2);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
